// File: rtl/dmem_acc_pkg.sv
// Shared encodings for the data-memory access controller: size codes, FSM states,
// memory address width and the alignment rule.
package dmem_acc_pkg;

    localparam int MEM_ADDR_W = 16;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } state_e;

    // Illegal size or a lane that straddles its natural boundary.
    function automatic logic bad_align(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Little-endian lane logic: extracts and extends a load lane, and merges store data
// into a read word. Shared by the load path and the read-modify-write path.
module dmem_lane_align
    import dmem_acc_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] store_data,
    output logic [31:0] load_val,
    output logic [31:0] merge_word
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane select, extension and merge; untouched lanes pass through bit-exact.
    always_comb begin
        byte_s     = word[{addr_lo, 3'b000} +: 8];
        half_s     = addr_lo[1] ? word[31:16] : word[15:0];
        load_val   = word;
        merge_word = word;
        case (size)
            SZ_BYTE: begin
                load_val = is_unsigned ? {24'd0, byte_s} : {{24{byte_s[7]}}, byte_s};
                merge_word[{addr_lo, 3'b000} +: 8] = store_data[7:0];
            end
            SZ_HALF: begin
                load_val = is_unsigned ? {16'd0, half_s} : {{16{half_s[15]}}, half_s};
                merge_word[{addr_lo[1], 4'b0000} +: 16] = store_data[15:0];
            end
            SZ_WORD: begin
                load_val   = word;
                merge_word = store_data;
            end
            default: begin
                load_val   = 32'd0;
                merge_word = word;
            end
        endcase
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// CPU load/store to single-port word memory controller with read-modify-write for
// sub-word stores. Optional address range check: DMEM_ACC_RANGE_CHECK_EN.
module dmem_access_ctrl
    import dmem_acc_pkg::*;
#(
    parameter int RD_LATENCY = 1,
    parameter int MEM_BYTES  = 65536
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic                  mem_write,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);

    localparam logic [1:0] LAT_LAST = 2'(RD_LATENCY - 1);

    state_e                  state_r;
    logic [1:0]              cnt_r;
    logic [1:0]              size_r;
    logic                    write_r;
    logic                    unsigned_r;
    logic [31:0]             wdata_r;
    logic                    req_ready_r;
    logic                    resp_valid_r;
    logic [31:0]             resp_rdata_r;
    logic                    resp_err_r;
    logic                    mem_write_r;
    logic [MEM_ADDR_W-1:0]   mem_addr_r;
    logic [31:0]             mem_wdata_r;
    logic                    range_err_s;
    logic                    err_s;
    logic [31:0]             load_s;
    logic [31:0]             merge_s;

`ifdef DMEM_ACC_RANGE_CHECK_EN
    assign range_err_s = (req_addr >= 32'(MEM_BYTES));
`else
    logic unused_addr_hi_s;
    assign range_err_s      = 1'b0;
    assign unused_addr_hi_s = ^{req_addr[31:MEM_ADDR_W], 32'(MEM_BYTES)};
`endif

    assign err_s = bad_align(req_size, req_addr[1:0]) | range_err_s;

    // mem_rdata feeds the aligner directly; results are only registered on the last RD cycle.
    dmem_lane_align u_align (
        .word        (mem_rdata),
        .addr_lo     (mem_addr_r[1:0]),
        .size        (size_r),
        .is_unsigned (unsigned_r),
        .store_data  (wdata_r),
        .load_val    (load_s),
        .merge_word  (merge_s)
    );

    // Access sequencer; all outputs are registered alongside the state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            cnt_r        <= 2'd0;
            size_r       <= 2'd0;
            write_r      <= 1'b0;
            unsigned_r   <= 1'b0;
            wdata_r      <= 32'd0;
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
            resp_rdata_r <= 32'd0;
            resp_err_r   <= 1'b0;
            mem_write_r  <= 1'b0;
            mem_addr_r   <= '0;
            mem_wdata_r  <= 32'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_valid) begin
                        req_ready_r <= 1'b0;
                        size_r      <= req_size;
                        write_r     <= req_write;
                        unsigned_r  <= req_unsigned;
                        wdata_r     <= req_wdata;
                        if (err_s) begin
                            state_r      <= RESP;
                            resp_valid_r <= 1'b1;
                            resp_err_r   <= 1'b1;
                            resp_rdata_r <= 32'd0;
                        end else if (req_write && (req_size == SZ_WORD)) begin
                            state_r     <= WR;
                            mem_addr_r  <= req_addr[MEM_ADDR_W-1:0];
                            mem_write_r <= 1'b1;
                            mem_wdata_r <= req_wdata;
                        end else begin
                            state_r    <= RD;
                            mem_addr_r <= req_addr[MEM_ADDR_W-1:0];
                            cnt_r      <= LAT_LAST;
                        end
                    end
                end
                RD: begin
                    if (cnt_r == 2'd0) begin
                        if (write_r) begin
                            state_r     <= WR;
                            mem_write_r <= 1'b1;
                            mem_wdata_r <= merge_s;
                        end else begin
                            state_r      <= RESP;
                            resp_valid_r <= 1'b1;
                            resp_err_r   <= 1'b0;
                            resp_rdata_r <= load_s;
                        end
                    end else begin
                        cnt_r <= cnt_r - 2'd1;
                    end
                end
                WR: begin
                    state_r      <= RESP;
                    mem_write_r  <= 1'b0;
                    resp_valid_r <= 1'b1;
                    resp_err_r   <= 1'b0;
                    resp_rdata_r <= 32'd0;
                end
                RESP: begin
                    state_r      <= IDLE;
                    req_ready_r  <= 1'b1;
                    resp_valid_r <= 1'b0;
                    resp_err_r   <= 1'b0;
                    resp_rdata_r <= 32'd0;
                end
                default: begin
                    state_r      <= IDLE;
                    req_ready_r  <= 1'b1;
                    resp_valid_r <= 1'b0;
                    resp_err_r   <= 1'b0;
                    resp_rdata_r <= 32'd0;
                    mem_write_r  <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_r;
    assign resp_valid = resp_valid_r;
    assign resp_rdata = resp_rdata_r;
    assign resp_err   = resp_err_r;
    assign mem_write  = mem_write_r;
    assign mem_addr   = mem_addr_r;
    assign mem_wdata  = mem_wdata_r;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboard bench for dmem_access_ctrl: one instance at RD_LATENCY=1, one at 3.
module tb_dmem_access_ctrl;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid0, req_valid3;
    logic        req_write, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;

    logic        req_ready0, resp_valid0, resp_err0, mem_write0;
    logic [31:0] resp_rdata0, mem_wdata0, mem_rdata0;
    logic [15:0] mem_addr0;
    logic        req_ready3, resp_valid3, resp_err3, mem_write3;
    logic [31:0] resp_rdata3, mem_wdata3, mem_rdata3;
    logic [15:0] mem_addr3;

    logic [31:0] mem_a [0:16383];
    logic [31:0] p1, p2;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    int          wr0_cnt = 0;
    int          wr3_cnt = 0;
    int          last_wr_cyc = 0;
    logic [31:0] last_wdata = 32'd0;
    exp_t        q0[$];
    exp_t        q3[$];
    exp_t        e0, e3;

    always #5 clock = ~clock;

    dmem_access_ctrl #(.RD_LATENCY(1), .MEM_BYTES(65536)) u_dut (
        .clock(clock), .reset(reset), .req_valid(req_valid0), .req_ready(req_ready0),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid0),
        .resp_rdata(resp_rdata0), .resp_err(resp_err0), .mem_write(mem_write0),
        .mem_addr(mem_addr0), .mem_wdata(mem_wdata0), .mem_rdata(mem_rdata0)
    );

    dmem_access_ctrl #(.RD_LATENCY(3), .MEM_BYTES(65536)) u_dut3 (
        .clock(clock), .reset(reset), .req_valid(req_valid3), .req_ready(req_ready3),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid3),
        .resp_rdata(resp_rdata3), .resp_err(resp_err3), .mem_write(mem_write3),
        .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3)
    );

    // Memory for the latency-1 instance: combinational read, word write on the edge.
    assign mem_rdata0 = mem_a[mem_addr0[15:2]];
    always @(posedge clock) begin
        if (mem_write0) mem_a[mem_addr0[15:2]] <= mem_wdata0;
        cyc <= cyc + 1;
    end

    // Latency-3 instance sees the same contents through two extra pipeline stages.
    always @(posedge clock) begin
        p1 <= mem_a[mem_addr3[15:2]];
        p2 <= p1;
    end
    assign mem_rdata3 = p2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Response monitor: pops the scoreboard and checks data, error flag and cycle.
    always @(negedge clock) begin
        if (resp_valid0) begin
            chk("resp0_expected", 32'(q0.size() != 0), 32'd1);
            if (q0.size() != 0) begin
                e0 = q0.pop_front();
                chk("resp0_rdata", resp_rdata0, e0.rdata);
                chk("resp0_err", 32'(resp_err0), 32'(e0.err));
                chk("resp0_cycle", 32'(cyc), 32'(e0.due));
            end
        end
        if (resp_valid3) begin
            chk("resp3_expected", 32'(q3.size() != 0), 32'd1);
            if (q3.size() != 0) begin
                e3 = q3.pop_front();
                chk("resp3_rdata", resp_rdata3, e3.rdata);
                chk("resp3_err", 32'(resp_err3), 32'(e3.err));
                chk("resp3_cycle", 32'(cyc), 32'(e3.due));
            end
        end
        if (mem_write0) begin
            wr0_cnt++;
            last_wr_cyc = cyc;
            last_wdata  = mem_wdata0;
        end
        if (mem_write3) wr3_cnt++;
    end

    task automatic issue(input int sel, input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] er, input logic ee, input int lat,
                         input bit push, output int acc);
        int n = 0;
        while (((sel == 0) ? !req_ready0 : !req_ready3) && n < 50) begin
            @(negedge clock);
            n++;
        end
        chk("ready_wait", 32'(n < 50), 32'd1);
        req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = wd;
        if (sel == 0) req_valid0 = 1'b1;
        else          req_valid3 = 1'b1;
        @(posedge clock);
        #1;
        acc = cyc;
        req_valid0 = 1'b0;
        req_valid3 = 1'b0;
        if (push) begin
            if (sel == 0) q0.push_back('{er, ee, acc + lat - 1});
            else          q3.push_back('{er, ee, acc + lat - 1});
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((q0.size() != 0 || q3.size() != 0) && n < 40) begin
            @(negedge clock);
            n++;
        end
        chk("drain", 32'(q0.size() + q3.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, acc_b, wr_before, n;
        int acc_k[2];
        reset = 1'b1;
        req_valid0 = 1'b0; req_valid3 = 1'b0; req_write = 1'b0; req_unsigned = 1'b0;
        req_size = 2'b00; req_addr = 32'd0; req_wdata = 32'd0;
        for (int i = 0; i < 16384; i++) mem_a[i] = 32'(i) * 32'h01010101;
        mem_a[4] = 32'h8899AABB;
        mem_a[5] = 32'h11223344;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("rst_ready", 32'(req_ready0), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid0), 32'd0);
        chk("rst_mem_write", 32'(mem_write0), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr0), 32'd0);
        chk("rst_rdata_err", {resp_rdata0[30:0], resp_err0}, 32'd0);

        issue(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 32'h8899AABB, 1'b0, 2, 1'b1, acc);
        issue(0, 1'b0, 2'b00, 1'b0, 32'h11, 32'd0, 32'hFFFFFFAA, 1'b0, 2, 1'b1, acc);
        issue(0, 1'b0, 2'b00, 1'b1, 32'h11, 32'd0, 32'h000000AA, 1'b0, 2, 1'b1, acc);
        issue(0, 1'b0, 2'b01, 1'b0, 32'h12, 32'd0, 32'hFFFF8899, 1'b0, 2, 1'b1, acc);
        issue(0, 1'b0, 2'b01, 1'b1, 32'h12, 32'd0, 32'h00008899, 1'b0, 2, 1'b1, acc);
        drain();
        chk("loads_no_write", 32'(wr0_cnt), 32'd0);

        wr_before = wr0_cnt;
        issue(0, 1'b1, 2'b00, 1'b0, 32'h12, 32'h123456CC, 32'd0, 1'b0, 3, 1'b1, acc);
        drain();
        chk("sb_one_write", 32'(wr0_cnt - wr_before), 32'd1);
        chk("sb_merge", last_wdata, 32'h88CCAABB);
        chk("sb_write_cycle", 32'(last_wr_cyc), 32'(acc + 1));
        issue(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 32'h88CCAABB, 1'b0, 2, 1'b1, acc);

        wr_before = wr0_cnt;
        issue(0, 1'b1, 2'b10, 1'b0, 32'h14, 32'hDEADBEEF, 32'd0, 1'b0, 2, 1'b1, acc);
        drain();
        chk("sw_one_write", 32'(wr0_cnt - wr_before), 32'd1);
        chk("sw_write_cycle", 32'(last_wr_cyc), 32'(acc));
        chk("sw_wdata", last_wdata, 32'hDEADBEEF);
        issue(0, 1'b0, 2'b10, 1'b0, 32'h14, 32'd0, 32'hDEADBEEF, 1'b0, 2, 1'b1, acc);
        issue(0, 1'b1, 2'b01, 1'b0, 32'h16, 32'hFFFF7777, 32'd0, 1'b0, 3, 1'b1, acc);
        issue(0, 1'b0, 2'b10, 1'b0, 32'h14, 32'd0, 32'h7777BEEF, 1'b0, 2, 1'b1, acc);
        issue(0, 1'b0, 2'b00, 1'b1, 32'h17, 32'd0, 32'h00000077, 1'b0, 2, 1'b1, acc);
        drain();

        wr_before = wr0_cnt;
        issue(0, 1'b1, 2'b01, 1'b0, 32'h15, 32'h0000FFFF, 32'd0, 1'b1, 1, 1'b1, acc);
        issue(0, 1'b0, 2'b11, 1'b0, 32'h10, 32'd0, 32'd0, 1'b1, 1, 1'b1, acc);
        issue(0, 1'b1, 2'b10, 1'b0, 32'h12, 32'hCAFEF00D, 32'd0, 1'b1, 1, 1'b1, acc);
        drain();
        chk("err_no_write", 32'(wr0_cnt - wr_before), 32'd0);
        issue(0, 1'b0, 2'b10, 1'b0, 32'h00010010, 32'd0, 32'h88CCAABB, 1'b0, 2, 1'b1, acc);
        drain();

        // Reset lands in the RD cycle of a half store: nothing may be written or answered.
        wr_before = wr0_cnt;
        issue(0, 1'b1, 2'b01, 1'b0, 32'h10, 32'h00005555, 32'd0, 1'b0, 3, 1'b0, acc);
        #1 reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        chk("abort_ready", 32'(req_ready0), 32'd1);
        chk("abort_no_write", 32'(wr0_cnt - wr_before), 32'd0);
        chk("abort_mem", mem_a[4], 32'h88CCAABB);
        issue(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 32'h88CCAABB, 1'b0, 2, 1'b1, acc);
        drain();

        // Back-to-back with req_valid held high.
        req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h10;
        req_valid0 = 1'b1;
        for (int k = 0; k < 2; k++) begin
            n = 0;
            while (!req_ready0 && n < 20) begin
                @(negedge clock);
                n++;
            end
            chk("b2b_ready_wait", 32'(n < 20), 32'd1);
            @(posedge clock);
            #1;
            acc_k[k] = cyc;
            q0.push_back('{32'h88CCAABB, 1'b0, cyc + 1});
        end
        req_valid0 = 1'b0;
        drain();
        chk("b2b_gap", 32'(acc_k[1] - acc_k[0]), 32'd3);

        issue(3, 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 32'h88CCAABB, 1'b0, 4, 1'b1, acc_b);
        issue(3, 1'b0, 2'b01, 1'b0, 32'h14, 32'd0, 32'hFFFFBEEF, 1'b0, 4, 1'b1, acc_b);
        drain();
        chk("lat3_no_write", 32'(wr3_cnt), 32'd0);

        repeat (2) @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Initiator side of the data-memory port: converts CPU load/store requests (byte, half, word; signed/unsigned) into single-port word accesses on the data memory.
- Sub-word stores use read-modify-write, because the memory has a single word-wide write enable.
- Sits between the execute/memory stage and the data-memory block. Owns alignment checks, lane extraction, sign extension and lane merge.

Parameters:
- RD_LATENCY, 1, cycles from mem_addr valid to mem_rdata valid; legal 1..3.
- MEM_BYTES, 65536, data-memory size in bytes; used only by the optional range check.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  controller idle, accepts request
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  loads: zero-extend when 1, sign-extend when 0
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned or illegal request, valid with resp_valid
- mem_write  out  1  word write enable to data memory
- mem_addr  out  16  byte address to data memory; memory uses [15:2]
- mem_wdata  out  32  write word
- mem_rdata  in  32  read word

Behaviour:
- Reset (async): state IDLE. All outputs 0 except req_ready = 1 after reset deasserts. Reset mid-operation aborts the operation: no write, no response.
- States and transitions:
  - IDLE: req_ready = 1. Accept on a rising edge with req_valid & req_ready. Latch addr, size, write, unsigned, wdata.
  - IDLE → RESP when the request is erroneous.
  - IDLE → WR for a word store.
  - IDLE → RD otherwise.
  - RD: mem_addr = latched addr[15:0]. A wait counter runs RD_LATENCY cycles. At the end of the last RD cycle, mem_rdata is captured.
  - RD → RESP for loads; RD → WR for sub-word stores.
  - WR: mem_write = 1 for exactly one cycle, with mem_addr and mem_wdata stable. WR → RESP.
  - RESP: resp_valid = 1 for one cycle, then → IDLE. There is no back-pressure on the response.
- req_ready is 0 in every state except IDLE. Requests presented while not ready are ignored, not queued.
- Latency in cycles after the accept edge:
  - Load: RD_LATENCY+1.
  - Word store: 2.
  - Sub-word store: RD_LATENCY+2.
  - Error: 1.
- Errors: set when any of the following holds. On error, mem_write is never asserted, resp_err = 1 and resp_rdata = 0.
  - req_size = 11.
  - Half with addr[0] = 1.
  - Word with addr[1:0] ≠ 0.
- Lanes are little-endian:
  - Byte n = addr[1:0] occupies bits [8n+7:8n].
  - Half h = addr[1] occupies bits [16h+15:16h].
- Load extraction: shift the selected lane to bit 0, then zero- or sign-extend per req_unsigned. Word loads pass through unchanged.
- Sub-word store merge: the captured read word with only the target lane replaced by the low bits of req_wdata. Other lanes are preserved bit-exact.
- Address bits [31:16] are ignored unless the optional feature is compiled in.
- mem_addr and mem_wdata hold their last values in IDLE. mem_write is 0 outside WR.

Optional Feature:
- Macro DMEM_ACC_RANGE_CHECK_EN.
- Defined: a request with req_addr ≥ MEM_BYTES is an error, handled identically to misalignment (1-cycle RESP, resp_err = 1, no access).
- Undefined: upper address bits are silently dropped, so addresses alias modulo 64 KiB.

Decomposition:
- Shared package dmem_acc_pkg holds:
  - Size encodings SZ_BYTE, SZ_HALF, SZ_WORD.
  - State enum {IDLE, RD, WR, RESP}.
  - MEM_ADDR_W = 16.
- One combinational sub-module, dmem_lane_align. Inputs: word, addr[1:0], size, unsigned, store data. Outputs: extracted load value and merged store word. It is shared by the load path and the RMW path.

Test Plan:
- Memory[0x0010] = 0x8899AABB, RD_LATENCY=1; lw 0x0010 → resp_valid exactly 2 cycles after accept, resp_rdata = 0x8899AABB, resp_err = 0, mem_write never high.
- lb 0x0011 → 0xFFFFFFAA; lbu 0x0011 → 0x000000AA; lh 0x0012 → 0xFFFF8899; lhu 0x0012 → 0x00008899.
- sb 0x0012 with wdata 0x123456CC → one read, then one mem_write pulse with mem_wdata = 0x88CCAABB. resp at cycle 3; the following lw 0x0010 returns 0x88CCAABB.
- sw 0x0014 with 0xDEADBEEF → mem_write exactly one cycle at cycle 1, resp at cycle 2. lh 0x0015 → resp_err = 1 at cycle 1, no mem_write. req_size = 11 → resp_err = 1.
- Assert reset during the RD cycle of sh 0x0010 → mem_write never asserted, no resp_valid, req_ready = 1 after release, memory unchanged.
- Back-to-back requests with req_valid held high → second accepted only in the cycle after RESP. RD_LATENCY=3 lw → resp at cycle 4.
